lcd_refresh_sequencer: RTL and testbench



---
 rtl/lcd_pkg.sv | 95 +++++++++
 rtl/lcd_byte_writer.sv | 86 ++++++++
 rtl/lcd_refresh_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_refresh_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and row character helpers for the
// 16x2 LCD refresh sequencer.
package lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, no cursor
  localparam logic [7:0] CLEAR      = 8'h01;  // clear display (slow command)
  localparam logic [7:0] ENTRY_MODE = 8'h06;  // increment, no shift
  localparam logic [7:0] ROW1_ADDR  = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] ROW2_ADDR  = 8'hC0;  // DDRAM address 0x40

  // ASCII glyphs used by the two rows
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_J     = 8'h4A;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_COLON = 8'h3A;

  localparam logic [3:0] LAST_COL       = 4'd15;
  localparam logic [1:0] LAST_INIT_STEP = 2'd3;
  localparam logic [1:0] CLEAR_STEP     = 2'd2;

  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } lcd_state_e;

  // Single decimal digit; anything that does not fit in one digit shows '*'.
  function automatic logic [7:0] digit_char(input logic [7:0] v);
    logic [7:0] c;
    if (v > 8'd9) c = CH_STAR;
    else          c = CH_0 + v;
    return c;
  endfunction

  // Power-on init command for a given step.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] c;
    case (step)
      2'd0:    c = FUNC_SET;
      2'd1:    c = DISP_ON;
      2'd2:    c = CLEAR;
      default: c = ENTRY_MODE;
    endcase
    return c;
  endfunction

  // Row 1: "H:h J:j E:e" padded with spaces.
  function automatic logic [7:0] row1_char(input logic [3:0] idx, input logic [7:0] h,
                                           input logic [7:0] j, input logic [7:0] e);
    logic [7:0] c;
    c = CH_SP;
    case (idx)
      4'd0:    c = CH_H;
      4'd1:    c = CH_COLON;
      4'd2:    c = digit_char(h);
      4'd4:    c = CH_J;
      4'd5:    c = CH_COLON;
      4'd6:    c = digit_char(j);
      4'd8:    c = CH_E;
      4'd9:    c = CH_COLON;
      4'd10:   c = digit_char(e);
      default: c = CH_SP;
    endcase
    return c;
  endfunction

  // Row 2: "FACE:f" padded with spaces.
  function automatic logic [7:0] row2_char(input logic [3:0] idx, input logic [7:0] f);
    logic [7:0] c;
    c = CH_SP;
    case (idx)
      4'd0:    c = CH_F;
      4'd1:    c = CH_A;
      4'd2:    c = CH_C;
      4'd3:    c = CH_E;
      4'd4:    c = CH_COLON;
      4'd5:    c = digit_char(f);
      default: c = CH_SP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte onto the LCD bus: a setup cycle, an enable pulse, then a
// post-wait with enable low. rs/data stay stable for the whole byte. done is
// high in the final cycle so the next byte can start with no gap.
module lcd_byte_writer #(
  parameter int EN_PULSE_CYCLES   = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data_in,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int MAX_WAIT = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES
                                                                  : CLEAR_WAIT_CYCLES;
  localparam int CW = $clog2(EN_PULSE_CYCLES + MAX_WAIT + 1);
  // cnt_q is the index of the current cycle within the byte: 0 = setup.
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_PULSE_CYCLES);
  localparam logic [CW-1:0] SHORT_LAST = CW'(EN_PULSE_CYCLES + CMD_WAIT_CYCLES);
  localparam logic [CW-1:0] LONG_LAST  = CW'(EN_PULSE_CYCLES + CLEAR_WAIT_CYCLES);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_q, long_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] last;

  // Next-state for the byte timing counter and bus outputs
  always_comb begin
    last     = long_q ? LONG_LAST : SHORT_LAST;
    done     = active_q && (cnt_q == last);
    active_d = active_q;
    cnt_d    = cnt_q;
    long_d   = long_q;
    rs_d     = rs_q;
    en_d     = en_q;
    data_d   = data_q;
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      cnt_d    = '0;
      long_d   = long_wait;
      rs_d     = rs;
      data_d   = data_in;
      en_d     = 1'b0;
    end else if (done) begin
      active_d = 1'b0;
      en_d     = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
      en_d  = (cnt_d <= EN_LAST);
    end
  end

  // Registered bus outputs; reset drops enable on the very next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      long_q   <= 1'b0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      long_q   <= long_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      data_q   <= data_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Power-on init of a 16x2 HD44780 LCD, then a full two-row rewrite on each
// update request. Stats are snapshotted at the start of a refresh; updates
// arriving while busy collapse into a single follow-up refresh.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int MAX_VALUE_STATISTICS = 5,
  parameter int NUM_FACES            = 9,
  parameter int EN_PULSE_CYCLES      = 25,
  parameter int CMD_WAIT_CYCLES      = 2500,
  parameter int CLEAR_WAIT_CYCLES    = 100000,
  parameter int POWERON_WAIT_CYCLES  = 1000000
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    new_update,
  input  logic [$clog2(NUM_FACES)-1:0]            face,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Hunger,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Joy,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Energy,
  output logic                                    lcd_rs,
  output logic                                    lcd_rw,
  output logic                                    lcd_en,
  output logic [7:0]                              lcd_data,
  output logic                                    busy
);

  localparam int FACE_W = $clog2(NUM_FACES);
  localparam int STAT_W = $clog2(MAX_VALUE_STATISTICS);
  localparam int PW_W   = (POWERON_WAIT_CYCLES > 1) ? $clog2(POWERON_WAIT_CYCLES) : 1;
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(POWERON_WAIT_CYCLES - 1);

  lcd_state_e        state_q, state_d;
  logic [3:0]        char_q, char_d;
  logic [1:0]        init_q, init_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic [FACE_W-1:0] snap_f_q, snap_f_d;
  logic [STAT_W-1:0] snap_h_q, snap_h_d;
  logic [STAT_W-1:0] snap_j_q, snap_j_d;
  logic [STAT_W-1:0] snap_e_q, snap_e_d;
  logic              go_refresh;
  logic              wr_start;
  logic              wr_rs;
  logic              wr_long;
  logic [7:0]        wr_byte;
  logic              wr_done;

  // Sequencer next state. state/char/init name the byte currently on the bus;
  // the next byte is launched in the same cycle the writer reports done.
  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    init_d     = init_q;
    pw_d       = pw_q;
    pend_d     = pend_q;
    snap_f_d   = snap_f_q;
    snap_h_d   = snap_h_q;
    snap_j_d   = snap_j_q;
    snap_e_d   = snap_e_q;
    go_refresh = 1'b0;
    wr_start   = 1'b0;

    if (new_update && (state_q != ST_IDLE)) pend_d = 1'b1;

    case (state_q)
      ST_POWER_WAIT: begin
        if (pw_q == PW_LAST) begin
          state_d  = ST_INIT;
          init_d   = 2'd0;
          wr_start = 1'b1;
        end else begin
          pw_d = pw_q + PW_W'(1);
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (init_q != LAST_INIT_STEP) begin
            init_d   = init_q + 2'd1;
            wr_start = 1'b1;
          end else if (pend_d) begin
            go_refresh = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (new_update) go_refresh = 1'b1;
      end
      ST_ADDR1: begin
        if (wr_done) begin
          state_d  = ST_LINE1;
          char_d   = 4'd0;
          wr_start = 1'b1;
        end
      end
      ST_LINE1: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (char_q == LAST_COL) state_d = ST_ADDR2;
          else                    char_d  = char_q + 4'd1;
        end
      end
      ST_ADDR2: begin
        if (wr_done) begin
          state_d  = ST_LINE2;
          char_d   = 4'd0;
          wr_start = 1'b1;
        end
      end
      ST_LINE2: begin
        if (wr_done) begin
          if (char_q != LAST_COL) begin
            char_d   = char_q + 4'd1;
            wr_start = 1'b1;
          end else if (pend_d) begin
            go_refresh = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_POWER_WAIT;
    endcase

    // Starting a refresh freezes the inputs and consumes any pending request
    if (go_refresh) begin
      state_d  = ST_ADDR1;
      pend_d   = 1'b0;
      snap_f_d = face;
      snap_h_d = Hunger;
      snap_j_d = Joy;
      snap_e_d = Energy;
      wr_start = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Byte selection for whatever position the sequencer is moving to
  always_comb begin
    wr_rs   = 1'b0;
    wr_long = 1'b0;
    wr_byte = 8'h00;
    case (state_d)
      ST_INIT: begin
        wr_byte = init_cmd(init_d);
        wr_long = (init_d == CLEAR_STEP);
      end
      ST_ADDR1: wr_byte = ROW1_ADDR;
      ST_LINE1: begin
        wr_rs   = 1'b1;
        wr_byte = row1_char(char_d, 8'(snap_h_q), 8'(snap_j_q), 8'(snap_e_q));
      end
      ST_ADDR2: wr_byte = ROW2_ADDR;
      ST_LINE2: begin
        wr_rs   = 1'b1;
        wr_byte = row2_char(char_d, 8'(snap_f_q));
      end
      default: wr_byte = 8'h00;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_POWER_WAIT;
      char_q   <= 4'd0;
      init_q   <= 2'd0;
      pw_q     <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b1;
      snap_f_q <= '0;
      snap_h_q <= '0;
      snap_j_q <= '0;
      snap_e_q <= '0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      init_q   <= init_d;
      pw_q     <= pw_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      snap_f_q <= snap_f_d;
      snap_h_q <= snap_h_d;
      snap_j_q <= snap_j_d;
      snap_e_q <= snap_e_d;
    end
  end

  lcd_byte_writer #(
    .EN_PULSE_CYCLES  (EN_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_writer (
    .clk      (clk),
    .reset    (reset),
    .start    (wr_start),
    .rs       (wr_rs),
    .data_in  (wr_byte),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  assign lcd_rw = 1'b0;
  assign busy   = busy_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Directed bench for lcd_refresh_sequencer with short timing parameters
// (enable 2, command wait 3, clear wait 10, power-on wait 20).
module tb_lcd_refresh_sequencer;

  localparam int EN = 2;

  logic       clk = 1'b0;
  logic       reset, new_update;
  logic [3:0] face;
  logic [2:0] Hunger, Joy, Energy;
  logic       lcd_rs, lcd_rw, lcd_en, busy;
  logic [7:0] lcd_data;

  lcd_refresh_sequencer #(
    .MAX_VALUE_STATISTICS(5), .NUM_FACES(9), .EN_PULSE_CYCLES(EN),
    .CMD_WAIT_CYCLES(3), .CLEAR_WAIT_CYCLES(10), .POWERON_WAIT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .new_update(new_update), .face(face),
    .Hunger(Hunger), .Joy(Joy), .Energy(Energy), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   h, j, e;
    logic [3:0]   f;
    logic [127:0] r1, r2;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t blog[$];
  int   total = 0, bad = 0;
  int   cyc = 0, en_len = 0;
  logic en_prev = 1'b0, abort = 1'b0;
  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Log every byte at its enable rising edge and check the pulse width
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      blog.push_back('{lcd_rs, lcd_data, cyc});
      en_len = 1;
    end else if (lcd_en) begin
      en_len++;
    end else if (en_prev && !abort) begin
      chk("en_width", en_len, EN);
    end
    en_prev = lcd_en;
  end

  task automatic wait_log(input int n);
    int k = 0;
    while (blog.size() < n && k < 5000) begin
      @(negedge clk); #1;
      k++;
    end
    if (blog.size() < n) chk("wait_log_timeout", blog.size(), n);
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic pulse;
    @(negedge clk); new_update = 1'b1;
    @(negedge clk); new_update = 1'b0;
  endtask

  task automatic set_in(input int h, input int j, input int e, input int f);
    Hunger = 3'(h); Joy = 3'(j); Energy = 3'(e); face = 4'(f);
  endtask

  // Expects reset to be high for the coming posedge; checks reset outputs
  // then the full power-wait + init sequence up to busy falling.
  task automatic reset_seq;
    int n, e0;
    int exp_b[4];
    int exp_t[4];
    exp_b = '{'h038, 'h00C, 'h001, 'h006};
    exp_t = '{21, 27, 33, 46};
    @(negedge clk);
    blog.delete();
    reset = 1'b0;
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_busy", int'(busy), 1);
    e0 = cyc;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    chk("init_busy_cycles", n, 51);
    chk("init_count", blog.size(), 4);
    if (blog.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("init_byte", int'({blog[i].rs, blog[i].d}), exp_b[i]);
        chk("init_time", blog[i].t - e0, exp_t[i]);
      end
  endtask

  task automatic check_refresh(input int base, input logic [127:0] r1, input logic [127:0] r2);
    logic [127:0] a1, a2;
    int rs_bad;
    if (blog.size() < base + 34) begin
      chk("refresh_len", blog.size(), base + 34);
      return;
    end
    a1 = '0; a2 = '0; rs_bad = 0;
    for (int i = 0; i < 16; i++) begin
      a1[(15-i)*8 +: 8] = blog[base+1+i].d;
      a2[(15-i)*8 +: 8] = blog[base+18+i].d;
      if (!blog[base+1+i].rs || !blog[base+18+i].rs) rs_bad++;
    end
    chk("addr1_cmd", int'({blog[base].rs, blog[base].d}), 'h080);
    chk("addr2_cmd", int'({blog[base+17].rs, blog[base+17].d}), 'h0C0);
    chk("char_rs", rs_bad, 0);
    total++;
    if (a1 != r1) begin
      bad++;
      $display("FAIL row1: got \"%s\" want \"%s\"", a1, r1);
    end
    total++;
    if (a2 != r2) begin
      bad++;
      $display("FAIL row2: got \"%s\" want \"%s\"", a2, r2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, n;
    vecs[0] = '{3'd3, 3'd2, 3'd4, 4'd7,  "H:3 J:2 E:4     ", "FACE:7          "};
    vecs[1] = '{3'd0, 3'd0, 3'd0, 4'd0,  "H:0 J:0 E:0     ", "FACE:0          "};
    vecs[2] = '{3'd7, 3'd5, 3'd1, 4'd10, "H:7 J:5 E:1     ", "FACE:*          "};
    vecs[3] = '{3'd6, 3'd3, 3'd7, 4'd9,  "H:6 J:3 E:7     ", "FACE:9          "};
    vecs[4] = '{3'd1, 3'd4, 3'd2, 4'd15, "H:1 J:4 E:2     ", "FACE:*          "};

    reset = 1'b1; new_update = 1'b0;
    set_in(0, 0, 0, 0);
    reset_seq();

    // Table: single refresh per vector
    for (int v = 0; v < 5; v++) begin
      Hunger = vecs[v].h; Joy = vecs[v].j; Energy = vecs[v].e; face = vecs[v].f;
      blog.delete();
      pulse();
      n = 1;
      while (busy && n < 3000) begin
        @(negedge clk);
        n++;
      end
      hi = n - 1;
      chk("busy_cycles", hi, 204);
      chk("refresh_count", blog.size(), 34);
      check_refresh(0, vecs[v].r1, vecs[v].r2);
    end

    // Input change mid-row must not reach the display
    set_in(3, 2, 4, 7);
    blog.delete();
    pulse();
    wait_log(7);
    Joy = 3'd1;
    wait_idle();
    check_refresh(0, "H:3 J:2 E:4     ", "FACE:7          ");

    // Two updates during one refresh -> exactly one follow-up, no gap
    set_in(1, 1, 1, 1);
    blog.delete();
    pulse();
    wait_log(5);
    set_in(2, 3, 4, 5);
    pulse();
    wait_log(20);
    pulse();
    wait_idle();
    chk("merge_count", blog.size(), 68);
    check_refresh(0, "H:1 J:1 E:1     ", "FACE:1          ");
    check_refresh(34, "H:2 J:3 E:4     ", "FACE:5          ");
    if (blog.size() >= 35) chk("merge_gap", blog[34].t - blog[33].t, 6);
    repeat (20) @(negedge clk);
    chk("merge_no_third", blog.size(), 68);

    // Update in the final cycle of LINE2 restarts with no idle cycle
    set_in(4, 4, 4, 4);
    blog.delete();
    pulse();
    wait_log(34);
    set_in(5, 6, 0, 3);
    repeat (4) begin
      @(negedge clk); #1;
    end
    new_update = 1'b1;
    @(posedge clk); #1;
    new_update = 1'b0;
    @(negedge clk);
    chk("last_cycle_busy", int'(busy), 1);
    wait_idle();
    chk("last_cycle_count", blog.size(), 68);
    if (blog.size() >= 35) chk("last_cycle_gap", blog[34].t - blog[33].t, 6);
    check_refresh(34, "H:5 J:6 E:0     ", "FACE:3          ");

    // Reset while enable is high in LINE2 aborts and reruns init
    set_in(2, 2, 2, 2);
    blog.delete();
    pulse();
    wait_log(20);
    chk("abort_en_high", int'(lcd_en), 1);
    abort = 1'b1;
    reset = 1'b1;
    reset_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
